// File: rtl/conv_loop_ctrl_l1.sv
// Layer-1 convolution loop sequencer: walks f > x > y > k > j, flags the first and
// last tap of each output pixel, and delays the last-tap flag into an output write strobe.
module conv_loop_ctrl_l1 #(
  parameter int X_MAX    = 29,
  parameter int Y_MAX    = 29,
  parameter int K_MAX    = 2,
  parameter int J_MAX    = 2,
  parameter int F_MAX    = 63,
  parameter int PIPE_LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stall,
  output logic [4:0] x,
  output logic [4:0] y,
  output logic [1:0] k,
  output logic [1:0] j,
  output logic [5:0] f,
  output logic       idx_vld,
  output logic       acc_clr,
  output logic       acc_last,
  output logic       out_we,
  output logic       busy,
  output logic       done
);

  localparam logic [4:0] X_TOP = 5'(X_MAX);
  localparam logic [4:0] Y_TOP = 5'(Y_MAX);
  localparam logic [1:0] K_TOP = 2'(K_MAX);
  localparam logic [1:0] J_TOP = 2'(J_MAX);
  localparam logic [5:0] F_TOP = 6'(F_MAX);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state, state_nxt;
  logic [4:0]          x_nxt, y_nxt;
  logic [1:0]          k_nxt, j_nxt;
  logic [5:0]          f_nxt;
  logic [PIPE_LAT-1:0] pipe, pipe_nxt;
  logic                j_last, k_last, y_last, x_last, f_last, tuple_last;

  assign j_last     = (j == J_TOP);
  assign k_last     = (k == K_TOP);
  assign y_last     = (y == Y_TOP);
  assign x_last     = (x == X_TOP);
  assign f_last     = (f == F_TOP);
  assign tuple_last = j_last & k_last & y_last & x_last & f_last;

  assign idx_vld  = (state == RUN) & ~stall;
  assign acc_clr  = idx_vld & (k == 2'd0) & (j == 2'd0);
  assign acc_last = idx_vld & k_last & j_last;
  assign out_we   = pipe[PIPE_LAT-1] & ~stall;
  assign busy     = (state == RUN) | (state == DRAIN);
  assign done     = (state == DONE);

  // Carry chain: every wrap resolves in the accepting cycle, so no bubble at a wrap.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    x_nxt = x;
    y_nxt = y;
    k_nxt = k;
    j_nxt = j;
    f_nxt = f;
    if (idx_vld) begin
      j_nxt = j_last ? 2'd0 : j + 2'd1;
      if (j_last) begin
        k_nxt = k_last ? 2'd0 : k + 2'd1;
        if (k_last) begin
          y_nxt = y_last ? 5'd0 : y + 5'd1;
          if (y_last) begin
            x_nxt = x_last ? 5'd0 : x + 5'd1;
            if (x_last) f_nxt = f_last ? 6'd0 : f + 6'd1;
          end
        end
      end
    end
  end

  // The write pipeline moves only on non-stalled cycles, so a stalled out_we is retried, never lost.
  always_comb begin
    pipe_nxt = pipe;
    if (!stall) begin
      pipe_nxt[0] = acc_last;
      for (int i = 1; i < PIPE_LAT; i++) pipe_nxt[i] = pipe[i-1];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (idx_vld && tuple_last) state_nxt = DRAIN;
      DRAIN:   if (pipe_nxt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      k     <= '0;
      j     <= '0;
      f     <= '0;
      pipe  <= '0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      k     <= k_nxt;
      j     <= j_nxt;
      f     <= f_nxt;
      pipe  <= pipe_nxt;
    end
  end

endmodule

// File: tb/tb_conv_loop_ctrl_l1.sv
// Directed bench for conv_loop_ctrl_l1 using a shrunk index space so full passes stay short.
module tb_conv_loop_ctrl_l1;

  localparam int XM = 3, YM = 2, KM = 2, JM = 2, FM = 2, PL = 3;
  localparam int N_TUP = (FM + 1) * (XM + 1) * (YM + 1) * (KM + 1) * (JM + 1);
  localparam int N_PIX = (FM + 1) * (XM + 1) * (YM + 1);

  logic       clk = 1'b0;
  logic       rst, start, stall;
  logic [4:0] x, y;
  logic [1:0] k, j;
  logic [5:0] f;
  logic       idx_vld, acc_clr, acc_last, out_we, busy, done;

  conv_loop_ctrl_l1 #(
    .X_MAX(XM), .Y_MAX(YM), .K_MAX(KM), .J_MAX(JM), .F_MAX(FM), .PIPE_LAT(PL)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .x(x), .y(y), .k(k), .j(j), .f(f),
    .idx_vld(idx_vld), .acc_clr(acc_clr), .acc_last(acc_last),
    .out_we(out_we), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0] f;
    logic [4:0] x;
    logic [4:0] y;
    logic [1:0] k;
    logic [1:0] j;
  } tup_t;

  typedef struct packed {
    logic       start, stall;
    logic       vld, clr, last, we, bsy, dn;
    logic [4:0] x, y;
    logic [1:0] k, j;
    logic [5:0] f;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  tup_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick(input logic s, input logic st, input logic r);
    @(posedge clk);
    #1;
    start = s;
    stall = st;
    rst   = r;
    @(negedge clk);
  endtask

  function automatic logic [25:0] obs();
    return {idx_vld, acc_clr, acc_last, out_we, busy, done, x, y, k, j, f};
  endfunction

  function automatic vec_t mk(logic st, logic sl, logic v, logic c, logic l, logic w,
                              logic b, logic d, logic [4:0] xx, logic [4:0] yy,
                              logic [1:0] kk, logic [1:0] jj, logic [5:0] ff);
    return '{st, sl, v, c, l, w, b, d, xx, yy, kk, jj, ff};
  endfunction

  task automatic fill_expected();
    exp_q.delete();
    for (int fi = 0; fi <= FM; fi++)
      for (int xi = 0; xi <= XM; xi++)
        for (int yi = 0; yi <= YM; yi++)
          for (int ki = 0; ki <= KM; ki++)
            for (int ji = 0; ji <= JM; ji++)
              exp_q.push_back('{6'(fi), 5'(xi), 5'(yi), 2'(ki), 2'(ji)});
  endtask

  // mode 0: no stall, 1: random ~30% stall, 2: no stall except 5 cycles inside DRAIN.
  task automatic run_pass(input int mode, input bit poke, input bit hold, input string tag);
    int   c_last = -1, c_done = -1, n_we = 0, n_tup = 0, gaps = 0;
    logic prev_busy = 1'b0;
    logic s, st;
    tup_t e;
    fill_expected();
    for (int c = 0; c < 5000 && c_done < 0; c++) begin
      s = (c == 0) || hold || (poke && prev_busy && $urandom_range(0, 3) == 0);
      case (mode)
        1:       st = ($urandom_range(0, 9) < 3);
        2:       st = (c_last >= 0) && (c >= c_last + 2) && (c <= c_last + 6);
        default: st = 1'b0;
      endcase
      tick(s, st, 1'b0);
      if (st) check({tag, " vld while stalled"}, idx_vld, 0);
      if (idx_vld) begin
        n_tup++;
        if (exp_q.size() == 0) check({tag, " extra tuple"}, n_tup, N_TUP);
        else begin
          e = exp_q.pop_front();
          check({tag, " tuple+flags"}, {f, x, y, k, j, acc_clr, acc_last},
                {e, (e.k == 2'd0 && e.j == 2'd0), (e.k == 2'(KM) && e.j == 2'(JM))});
          if (exp_q.size() == 0) c_last = c;
        end
      end else if (mode == 0 && c >= 1 && exp_q.size() > 0) begin
        gaps++;
      end
      if (out_we) n_we++;
      if (done) begin
        c_done = c;
        check({tag, " busy in done cycle"}, busy, 0);
      end
      prev_busy = busy;
    end
    check({tag, " done seen"}, c_done >= 0, 1);
    check({tag, " tuple count"}, n_tup, N_TUP);
    check({tag, " out_we count"}, n_we, N_PIX);
    if (mode == 0) begin
      check({tag, " gap cycles"}, gaps, 0);
      check({tag, " done latency"}, c_done - c_last, 1 + PL);
    end
    if (mode == 2) check({tag, " done latency drain stall"}, c_done - c_last, 1 + PL + 5);
    tick(hold, 1'b0, 1'b0);
    check({tag, " done one cycle"}, done, 0);
    check({tag, " busy after pass"}, busy, 0);
  endtask

  initial begin
    vec_t vecs[$];
    int   viol;
    bit   seen;

    rst = 1'b1; start = 1'b0; stall = 1'b0;
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);

    //          st sl vld clr lst we bsy dn  x  y  k  j  f
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 2, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 2, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 2, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 2, 2, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 2, 0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 1, 0));

    foreach (vecs[i]) begin
      tick(vecs[i].start, vecs[i].stall, 1'b0);
      check($sformatf("vector %0d", i), obs(),
            {vecs[i].vld, vecs[i].clr, vecs[i].last, vecs[i].we, vecs[i].bsy, vecs[i].dn,
             vecs[i].x, vecs[i].y, vecs[i].k, vecs[i].j, vecs[i].f});
    end

    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    run_pass(0, 1'b0, 1'b0, "nostall");
    run_pass(1, 1'b0, 1'b0, "randstall");
    run_pass(2, 1'b0, 1'b0, "drainstall");
    run_pass(0, 1'b1, 1'b0, "startpoke");
    run_pass(0, 1'b0, 1'b1, "starthold");

    tick(1'b1, 1'b0, 1'b0);
    check("hold restart first tuple", obs(), {6'b110010, 20'd0});
    tick(1'b0, 1'b0, 1'b0);
    check("hold restart second tuple", obs(), {6'b100010, 5'd0, 5'd0, 2'd0, 2'd1, 6'd0});

    // Abort right after a last tap so a write is still in flight.
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      tick(1'b0, 1'b0, 1'b0);
      seen = acc_last && (f == 6'd1);
    end
    check("abort point reached", seen, 1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    check("outputs after mid-pass reset", obs(), 26'd0);
    viol = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1'b0, 1'b0, 1'b0);
      if (out_we || done || busy) viol++;
    end
    check("activity after abort", viol, 0);
    run_pass(0, 1'b0, 1'b0, "restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
